// File: rtl/add32_serial_pkg.sv
// -----------------------------------------------------------------------------
// add32_serial_pkg
//   Shared definitions for the nibble-serial adder/subtractor.
//   - state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - ADD32_DEF_WIDTH : default operand width
//   - nib_count : number of 4-bit steps for a given operand width
// -----------------------------------------------------------------------------
package add32_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned ADD32_DEF_WIDTH = 32;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / 4;
    endfunction

endpackage

// File: rtl/add32_serial_add4b.sv
// -----------------------------------------------------------------------------
// add4b
//   4-bit carry-lookahead adder slice.
//   Ports:
//     ai, bi : 4-bit operands
//     C0     : carry into bit 0
//     s      : 4-bit sum
//     GG     : group generate (slice produces a carry regardless of C0)
//     GP     : group propagate (slice passes C0 through to its carry out)
//   Carry out of the slice is GG | (GP & C0); the caller forms it.
// -----------------------------------------------------------------------------
module add4b (
    input  logic [3:0] ai,
    input  logic [3:0] bi,
    input  logic       C0,
    output logic [3:0] s,
    output logic       GG,
    output logic       GP
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = ai & bi;
        p = ai ^ bi;

        c[0] = C0;
        c[1] = g[0] | (p[0] & C0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & C0);

        s  = p ^ c;
        GP = &p;
        GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/add32_serial.sv
// -----------------------------------------------------------------------------
// add32_serial
//   Nibble-serial WIDTH-bit adder/subtractor. One add4b slice is reused for
//   NIB = WIDTH/4 cycles, low nibble first, with the ripple carry held in a
//   register between steps.
//   Ports:
//     clk, rst : rising-edge clock, synchronous active-high reset
//     start    : request, sampled only when not busy
//     sub      : 1 = a - b, 0 = a + b + cin
//     a, b     : operands, captured on an accepted start
//     cin      : carry in (ignored when sub=1)
//     busy     : high while nibbles are being processed
//     done     : one-cycle pulse, result valid
//     sum      : result, stable from done until the next accepted start
//     cout     : carry out of MSB (for sub, 1 = no borrow)
//     ovf      : signed overflow
//     zero     : sum == 0
// -----------------------------------------------------------------------------
module add32_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    import add32_serial_pkg::*;

    localparam int unsigned NIB   = nib_count(WIDTH);
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("add32_serial: WIDTH must be a non-zero multiple of 4");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         nib_s;
    logic               nib_gg;
    logic               nib_gp;

    // Nibble-select mux kept apart from the next-state logic so the slice
    // inputs do not depend on a block that also consumes the slice outputs.
    always_comb begin
        nib_a = a_q[cnt_q*4 +: 4];
        nib_b = b_q[cnt_q*4 +: 4];
    end

    add4b u_slice (
        .ai (nib_a),
        .bi (nib_b),
        .C0 (carry_q),
        .s  (nib_s),
        .GG (nib_gg),
        .GP (nib_gp)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[cnt_q*4 +: 4] = nib_s;
                carry_d = nib_gg | (nib_gp & carry_q);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIB - 1)) begin
                    state_d = ST_DONE;
                    cout_d  = carry_d;
                    // Carry into the MSB recovered from its sum bit.
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3]) ^ carry_d;
                    zero_d  = (sum_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
